// File: rtl/sram_dual_sync_bwe.sv
// Dual-port synchronous SRAM with byte write enables, configurable read-during-write,
// optional output register and a one-word-per-cycle clear sequencer.
module sram_dual_sync_bwe #(
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           ADDR_WIDTH     = 10,
  parameter int unsigned           RDW_MODE       = 0,
  parameter int unsigned           OUT_REG        = 0,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr_req,
  output logic                    clr_busy,
  input  logic                    cen_a,
  input  logic                    cen_b,
  input  logic                    we_a,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_a,
  input  logic [DATA_WIDTH-1:0]   data_b,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    qv_a,
  output logic                    qv_b,
  output logic                    coll
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rst_clr_q, rst_clr_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clr_active;
  logic                    port_en;
  logic                    rd_a, rd_b, wr_a, wr_b;
  logic [DATA_WIDTH-1:0]   old_a, old_b, merged_a, merged_b;
  logic [DATA_WIDTH-1:0]   q1_a_q, q1_a_d, q1_b_q, q1_b_d;
  logic                    qv1_a_q, qv1_a_d, qv1_b_q, qv1_b_d;
  logic [DATA_WIDTH-1:0]   q2_a_q, q2_a_d, q2_b_q, q2_b_d;
  logic                    qv2_a_q, qv2_a_d, qv2_b_q, qv2_b_d;
  logic                    coll_q, coll_d;

  // rst_clr_q stands in for the first clear cycle right after reset release,
  // so the reset-triggered clear covers exactly DEPTH cycles of clr_busy.
  assign clr_active = (state_q == S_CLEAR) | rst_clr_q;
  assign clr_busy   = clr_active;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_clr_d = 1'b0;
    if (clr_active) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (&cnt_q) ? S_IDLE : S_CLEAR;
    end else if (clr_req) begin
      cnt_d   = '0;
      state_d = S_CLEAR;
    end
  end

  assign port_en = reset_n & ~clr_active;
  assign rd_a    = port_en & cen_a;
  assign rd_b    = port_en & cen_b;
  assign wr_a    = rd_a & we_a;
  assign wr_b    = rd_b & we_b;
  assign old_a   = mem[addr_a];
  assign old_b   = mem[addr_b];

  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (be_a[i]) merged_a[i*8 +: 8] = data_a[i*8 +: 8];
      if (be_b[i]) merged_b[i*8 +: 8] = data_b[i*8 +: 8];
    end
  end

  // Read path: stage 1 captures the array, stage 2 is the optional output register.
  always_comb begin
    q1_a_d  = q1_a_q;
    q1_b_d  = q1_b_q;
    qv1_a_d = rd_a;
    qv1_b_d = rd_b;
    if (rd_a) q1_a_d = ((RDW_MODE != 0) && wr_a) ? merged_a : old_a;
    if (rd_b) q1_b_d = ((RDW_MODE != 0) && wr_b) ? merged_b : old_b;
    qv2_a_d = qv1_a_q;
    qv2_b_d = qv1_b_q;
    q2_a_d  = qv1_a_q ? q1_a_q : q2_a_q;
    q2_b_d  = qv1_b_q ? q1_b_q : q2_b_q;
    coll_d  = port_en & cen_a & cen_b & (addr_a == addr_b) &
              ((we_a & (|be_a)) | (we_b & (|be_b)));
  end

  assign q_a  = (OUT_REG != 0) ? q2_a_q  : q1_a_q;
  assign q_b  = (OUT_REG != 0) ? q2_b_q  : q1_b_q;
  assign qv_a = (OUT_REG != 0) ? qv2_a_q : qv1_a_q;
  assign qv_b = (OUT_REG != 0) ? qv2_b_q : qv1_b_q;
  assign coll = coll_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rst_clr_q <= (CLEAR_ON_RESET != 0);
      q1_a_q    <= '0;
      q1_b_q    <= '0;
      qv1_a_q   <= 1'b0;
      qv1_b_q   <= 1'b0;
      q2_a_q    <= '0;
      q2_b_q    <= '0;
      qv2_a_q   <= 1'b0;
      qv2_b_q   <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_clr_q <= rst_clr_d;
      q1_a_q    <= q1_a_d;
      q1_b_q    <= q1_b_d;
      qv1_a_q   <= qv1_a_d;
      qv1_b_q   <= qv1_b_d;
      q2_a_q    <= q2_a_d;
      q2_b_q    <= q2_b_d;
      qv2_a_q   <= qv2_a_d;
      qv2_b_q   <= qv2_b_d;
      coll_q    <= coll_d;
    end
  end

  // Array has no reset; port A is applied last so it wins shared bytes.
  always_ff @(posedge clk) begin
    if (clr_active && reset_n) begin
      mem[cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && be_b[i]) mem[addr_b][i*8 +: 8] <= data_b[i*8 +: 8];
        if (wr_a && be_a[i]) mem[addr_a][i*8 +: 8] <= data_a[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_dual_sync_bwe.sv
// Bench for sram_dual_sync_bwe: two instances (old-data/no out reg, new-data/out reg)
// share stimulus; per-stream expected queues carry data and due cycle.
module tb_sram_dual_sync_bwe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clr_req;
  logic        cen_a, cen_b, we_a, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;

  logic        clr_busy0, clr_busy1, qv_a0, qv_a1, qv_b0, qv_b1, coll0, coll1;
  logic [15:0] q_a0, q_a1, q_b0, q_b1;

  sram_dual_sync_bwe #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(0),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut0 (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .clr_busy(clr_busy0),
    .cen_a(cen_a), .cen_b(cen_b), .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a0), .q_b(q_b0), .qv_a(qv_a0), .qv_b(qv_b0), .coll(coll0));

  sram_dual_sync_bwe #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) dut1 (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .clr_busy(clr_busy1),
    .cen_a(cen_a), .cen_b(cen_b), .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .q_a(q_a1), .q_b(q_b1), .qv_a(qv_a1), .qv_b(qv_b1), .coll(coll1));

  int          checks;
  int          errors;
  int          cyc;
  logic        exp_coll_nxt;
  logic [15:0] model [16];
  // Streams: 0 = A/dut0, 1 = A/dut1, 2 = B/dut0, 3 = B/dut1
  logic [15:0] exp_q [4][$];
  int          due_q [4][$];
  logic [15:0] last_q [4];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic push(input int s, input logic [15:0] v, input int due);
    exp_q[s].push_back(v);
    due_q[s].push_back(due);
  endtask

  task automatic check_stream(input int s, input logic qv, input logic [15:0] q);
    if (due_q[s].size() > 0 && due_q[s][0] == cyc) begin
      check($sformatf("qv_s%0d_c%0d", s, cyc), {15'b0, qv}, 16'd1);
      check($sformatf("q_s%0d_c%0d", s, cyc), q, exp_q[s][0]);
      last_q[s] = exp_q[s][0];
      void'(exp_q[s].pop_front());
      void'(due_q[s].pop_front());
    end else begin
      check($sformatf("qv_idle_s%0d_c%0d", s, cyc), {15'b0, qv}, 16'd0);
      check($sformatf("q_hold_s%0d_c%0d", s, cyc), q, last_q[s]);
    end
  endtask

  task automatic tick();
    logic ec;
    ec = exp_coll_nxt;
    exp_coll_nxt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check($sformatf("coll0_c%0d", cyc), {15'b0, coll0}, {15'b0, ec});
    check($sformatf("coll1_c%0d", cyc), {15'b0, coll1}, {15'b0, ec});
    check_stream(0, qv_a0, q_a0);
    check_stream(1, qv_a1, q_a1);
    check_stream(2, qv_b0, q_b0);
    check_stream(3, qv_b1, q_b1);
  endtask

  task automatic idle();
    cen_a = 0; we_a = 0; be_a = 0; addr_a = 0; data_a = 0;
    cen_b = 0; we_b = 0; be_b = 0; addr_b = 0; data_b = 0;
  endtask

  task automatic op(input logic ea, input logic wa, input logic [1:0] bea,
                    input logic [3:0] aa, input logic [15:0] da,
                    input logic eb, input logic wb, input logic [1:0] beb,
                    input logic [3:0] ab, input logic [15:0] db, input logic ec);
    logic [15:0] old_a, old_b;
    cen_a = ea; we_a = wa; be_a = bea; addr_a = aa; data_a = da;
    cen_b = eb; we_b = wb; be_b = beb; addr_b = ab; data_b = db;
    exp_coll_nxt = ec;
    old_a = model[aa];
    old_b = model[ab];
    if (ea) begin
      push(0, old_a, cyc + 1);
      push(1, wa ? merge(old_a, da, bea) : old_a, cyc + 2);
    end
    if (eb) begin
      push(2, old_b, cyc + 1);
      push(3, wb ? merge(old_b, db, beb) : old_b, cyc + 2);
    end
    if (eb && wb) model[ab] = merge(model[ab], db, beb);
    if (ea && wa) model[aa] = merge(model[aa], da, bea);
    tick();
    idle();
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  // Counts busy cycles until both instances go idle; mode 1 adds a second
  // clr_req and port traffic (including a same-address pair) during the clear.
  task automatic measure(input int mode, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int g = 0; g < 64 && (clr_busy0 || clr_busy1); g++) begin
      if (clr_busy0) n0++;
      if (clr_busy1) n1++;
      if (mode == 1) begin
        clr_req = (g == 5);
        cen_a = 1; we_a = 1; be_a = 2'b11; addr_a = 4'(g); data_a = 16'hFFFF;
        cen_b = 1; we_b = 1; be_b = 2'b11; data_b = 16'h0F0F;
        addr_b = (g == 3) ? 4'(g) : 4'(15 - g);
      end
      tick();
    end
    clr_req = 0;
    idle();
  endtask

  task automatic fill_model();
    for (int i = 0; i < 16; i++) model[i] = 16'hA5A5;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) op(1, 0, 2'b00, 4'(i), 16'h0, 1, 0, 2'b00, 4'(15 - i), 16'h0, 0);
    flush();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy0"}, {15'b0, clr_busy0}, 16'd1);
    check({tag, "_busy1"}, {15'b0, clr_busy1}, 16'd1);
    check({tag, "_q_a0"}, q_a0, 16'h0);
    check({tag, "_q_a1"}, q_a1, 16'h0);
    check({tag, "_q_b0"}, q_b0, 16'h0);
    check({tag, "_q_b1"}, q_b1, 16'h0);
    check({tag, "_qv"}, {12'b0, qv_a0, qv_a1, qv_b0, qv_b1}, 16'h0);
    check({tag, "_coll"}, {14'b0, coll0, coll1}, 16'h0);
  endtask

  int n0, n1;

  initial begin
    checks = 0; errors = 0; cyc = 0; exp_coll_nxt = 0;
    for (int s = 0; s < 4; s++) last_q[s] = 16'h0;
    reset_n = 0; clr_req = 0;
    idle();
    repeat (3) tick();
    check_reset_outputs("rst");

    // Reset release: clear of 16 cycles, then every word reads the fill value.
    reset_n = 1;
    measure(0, n0, n1);
    check("busy_rst_len0", 16'(n0), 16'd16);
    check("busy_rst_len1", 16'(n1), 16'd16);
    fill_model();
    read_all();

    // Partial byte write then read back.
    op(1, 1, 2'b01, 4'd3, 16'h1234, 0, 0, 2'b00, 4'd0, 16'h0, 0);
    op(1, 0, 2'b00, 4'd3, 16'h0, 1, 0, 2'b00, 4'd3, 16'h0, 0);
    flush();

    // Same-address double write: A wins byte 0, B supplies byte 1.
    op(1, 1, 2'b01, 4'd5, 16'h1111, 1, 1, 2'b11, 4'd5, 16'h2222, 1);
    op(1, 0, 2'b00, 4'd5, 16'h0, 1, 0, 2'b00, 4'd5, 16'h0, 0);
    // Write-only-by-B collision and a zero-be write (no collision).
    op(1, 0, 2'b00, 4'd6, 16'h0, 1, 1, 2'b10, 4'd6, 16'h7700, 1);
    op(1, 1, 2'b00, 4'd6, 16'h9999, 1, 0, 2'b00, 4'd6, 16'h0, 0);
    op(1, 0, 2'b00, 4'd6, 16'h0, 0, 0, 2'b00, 4'd0, 16'h0, 0);
    flush();

    // Read-during-write on the same port and across ports.
    op(1, 1, 2'b11, 4'd7, 16'hBEEF, 1, 0, 2'b00, 4'd7, 16'h0, 1);
    op(1, 0, 2'b00, 4'd7, 16'h0, 1, 0, 2'b00, 4'd7, 16'h0, 0);
    flush();

    // Software clear with a second request and port traffic mid-clear.
    op(1, 1, 2'b11, 4'd9, 16'h0BAD, 0, 0, 2'b00, 4'd0, 16'h0, 0);
    flush();
    clr_req = 1;
    tick();
    clr_req = 0;
    measure(1, n0, n1);
    check("busy_req_len0", 16'(n0), 16'd16);
    check("busy_req_len1", 16'(n1), 16'd16);
    fill_model();
    read_all();

    // Reset pulsed during clear cycle 8: outputs drop at once, clear restarts.
    op(1, 1, 2'b11, 4'd12, 16'h1234, 1, 0, 2'b00, 4'd0, 16'h0, 0);
    flush();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (8) tick();
    #2;
    reset_n = 0;
    #1;
    check_reset_outputs("rst_mid");
    for (int s = 0; s < 4; s++) last_q[s] = 16'h0;
    @(negedge clk);
    reset_n = 1;
    measure(0, n0, n1);
    check("busy_mid_len0", 16'(n0), 16'd16);
    check("busy_mid_len1", 16'(n1), 16'd16);
    fill_model();
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
